// File: rtl/pll_drp_sequencer.sv
// rtl/pll_drp_sequencer.sv - PLLE2_ADV DRP reconfiguration sequencer
//
// Purpose:
//   Holds the PLL in reset and walks a parent-supplied table doing a
//   read-modify-write of each DRP register. It then releases reset and
//   waits for a synchronized LOCKED, with a timeout. DCLK is clk100.
//
// Ports:
//   clk100      system clock, also the PLL DCLK
//   rst         asynchronous active-high reset
//   start       one-cycle request to begin a reconfiguration
//   busy        sequence in progress
//   done        one-cycle pulse: sequence finished and PLL locked
//   err         one-cycle pulse: sequence aborted
//   err_code    1 = read DRDY timeout, 2 = write DRDY timeout,
//               3 = lock timeout (or readback mismatch); held until next start
//   tbl_idx     current table index presented to the parent
//   tbl_addr    DRP address for tbl_idx (combinational from parent)
//   tbl_mask    1 = preserve the existing register bit
//   tbl_data    new bit values where mask = 0
//   drp_*       PLL DRP pins (DEN, DWE, DADDR, DI, DO, DRDY)
//   pll_rst     PLL RST request (parent ORs this with rst)
//   pll_locked  PLL LOCKED, asynchronous to clk100
//
// Optional build macro:
//   PLL_DRP_READBACK_EN  re-read every written register and compare it with
//                        the value written (mismatch = code 3, DRDY timeout
//                        on the re-read = code 1)

`timescale 1ns/1ps

module pll_drp_sequencer #(
    parameter int NUM_ENTRIES  = 8,
    parameter int DRP_TIMEOUT  = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int RST_HOLD     = 16
) (
    input  logic        clk100,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [4:0]  tbl_idx,
    input  logic [6:0]  tbl_addr,
    input  logic [15:0] tbl_mask,
    input  logic [15:0] tbl_data,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        pll_rst,
    input  logic        pll_locked
);

    // One shared cycle counter serves HOLD, both DRDY waits and the lock
    // wait; it is wide enough for the largest of the three limits.
    localparam int MAX_A   = (DRP_TIMEOUT > RST_HOLD) ? DRP_TIMEOUT : RST_HOLD;
    localparam int CNT_MAX = (LOCK_TIMEOUT > MAX_A) ? LOCK_TIMEOUT : MAX_A;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] DRP_LAST  = CW'(DRP_TIMEOUT - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [4:0]    LAST_IDX  = 5'(NUM_ENTRIES - 1);

    localparam logic [1:0] CODE_RD   = 2'd1;
    localparam logic [1:0] CODE_WR   = 2'd2;
    localparam logic [1:0] CODE_LOCK = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HOLD,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_WR_WAIT,
        S_VRD,
        S_VRD_WAIT,
        S_RELEASE,
        S_LOCK_WAIT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cnt_inc;
    logic [4:0]     idx_q, idx_d;
    logic [6:0]     addr_q, addr_d;
    logic [15:0]    mask_q, mask_d;
    logic [15:0]    data_q, data_d;
    logic [15:0]    di_q, di_d;
    logic [1:0]     code_q, code_d;
    logic           pll_rst_q, pll_rst_d;
    logic           lock_meta_q, lock_meta_d;
    logic           lock_sync_q, lock_sync_d;
    logic           entry_done;

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            di_q        <= '0;
            code_q      <= '0;
            pll_rst_q   <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            di_q        <= di_d;
            code_q      <= code_d;
            pll_rst_q   <= pll_rst_d;
            lock_meta_q <= lock_meta_d;
            lock_sync_q <= lock_sync_d;
        end
    end

    // Saturating increment: a stuck wait can never wrap back under its limit.
    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_inc;
        idx_d       = idx_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        data_d      = data_q;
        di_d        = di_q;
        code_d      = code_q;
        pll_rst_d   = pll_rst_q;
        lock_meta_d = pll_locked;
        lock_sync_d = lock_meta_q;
        entry_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d   = S_HOLD;
                    pll_rst_d = 1'b1;
                    idx_d     = '0;
                    code_d    = '0;
                end
            end

            S_HOLD: begin
                if (cnt_q >= HOLD_LAST) begin
                    state_d = S_RD;
                end
            end

            S_RD: begin
                // The table is only guaranteed to match tbl_idx now, so the
                // whole entry is captured for the rest of the access.
                addr_d  = tbl_addr;
                mask_d  = tbl_mask;
                data_d  = tbl_data;
                cnt_d   = '0;
                state_d = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                if (drp_drdy) begin
                    di_d    = (drp_do & mask_q) | (data_q & ~mask_q);
                    state_d = S_WR;
                end else if (cnt_q >= DRP_LAST) begin
                    code_d    = CODE_RD;
                    pll_rst_d = 1'b1;
                    state_d   = S_FAIL;
                end
            end

            S_WR: begin
                cnt_d   = '0;
                state_d = S_WR_WAIT;
            end

            S_WR_WAIT: begin
                if (drp_drdy) begin
`ifdef PLL_DRP_READBACK_EN
                    state_d = S_VRD;
`else
                    entry_done = 1'b1;
`endif
                end else if (cnt_q >= DRP_LAST) begin
                    code_d    = CODE_WR;
                    pll_rst_d = 1'b1;
                    state_d   = S_FAIL;
                end
            end

`ifdef PLL_DRP_READBACK_EN
            S_VRD: begin
                cnt_d   = '0;
                state_d = S_VRD_WAIT;
            end

            S_VRD_WAIT: begin
                if (drp_drdy) begin
                    if (drp_do != di_q) begin
                        code_d    = CODE_LOCK;
                        pll_rst_d = 1'b1;
                        state_d   = S_FAIL;
                    end else begin
                        entry_done = 1'b1;
                    end
                end else if (cnt_q >= DRP_LAST) begin
                    code_d    = CODE_RD;
                    pll_rst_d = 1'b1;
                    state_d   = S_FAIL;
                end
            end
`endif

            S_RELEASE: begin
                pll_rst_d = 1'b0;
                cnt_d     = '0;
                state_d   = S_LOCK_WAIT;
            end

            S_LOCK_WAIT: begin
                // A stale LOCKED cannot get here: RST has been high far longer
                // than the synchronizer depth, so the PLL has dropped it.
                if (lock_sync_q) begin
                    state_d = S_DONE;
                end else if (cnt_q >= LOCK_LAST) begin
                    code_d    = CODE_LOCK;
                    pll_rst_d = 1'b1;
                    state_d   = S_FAIL;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_FAIL: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (entry_done) begin
            if (idx_q >= LAST_IDX) begin
                state_d = S_RELEASE;
            end else begin
                idx_d   = idx_q + 5'd1;
                state_d = S_RD;
            end
        end
    end

    assign busy      = !(state_q inside {S_IDLE, S_DONE, S_FAIL});
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_FAIL);
    assign err_code  = code_q;
    assign tbl_idx   = idx_q;
    assign drp_den   = (state_q == S_RD) || (state_q == S_WR) || (state_q == S_VRD);
    assign drp_dwe   = (state_q == S_WR);
    assign drp_daddr = (state_q == S_RD) ? tbl_addr : addr_q;
    assign drp_di    = di_q;
    assign pll_rst   = pll_rst_q;

endmodule

// File: tb/tb_pll_drp_sequencer.sv
// tb/tb_pll_drp_sequencer.sv - scoreboard bench for pll_drp_sequencer

`timescale 1ns/1ps

module tb_pll_drp_sequencer;

    localparam int NE      = 4;
    localparam int DRP_TO  = 64;
    localparam int LOCK_TO = 65536;
    localparam int HOLD    = 16;
`ifdef PLL_DRP_READBACK_EN
    localparam int DEN_PER_ENTRY = 3;
    localparam bit RB            = 1'b1;
`else
    localparam int DEN_PER_ENTRY = 2;
    localparam bit RB            = 1'b0;
`endif

    logic        clk100 = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [4:0]  tbl_idx;
    logic [6:0]  tbl_addr;
    logic [15:0] tbl_mask, tbl_data;
    logic        drp_den, drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di, drp_do;
    logic        drp_drdy;
    logic        pll_rst;
    logic        pll_locked;

    always #5 clk100 = ~clk100;

    pll_drp_sequencer #(
        .NUM_ENTRIES (NE),
        .DRP_TIMEOUT (DRP_TO),
        .LOCK_TIMEOUT(LOCK_TO),
        .RST_HOLD    (HOLD)
    ) dut (
        .clk100    (clk100),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .tbl_idx   (tbl_idx),
        .tbl_addr  (tbl_addr),
        .tbl_mask  (tbl_mask),
        .tbl_data  (tbl_data),
        .drp_den   (drp_den),
        .drp_dwe   (drp_dwe),
        .drp_daddr (drp_daddr),
        .drp_di    (drp_di),
        .drp_do    (drp_do),
        .drp_drdy  (drp_drdy),
        .pll_rst   (pll_rst),
        .pll_locked(pll_locked)
    );

    logic [6:0]  t_addr [NE];
    logic [15:0] t_mask [NE];
    logic [15:0] t_data [NE];
    assign tbl_addr = t_addr[tbl_idx[1:0]];
    assign tbl_mask = t_mask[tbl_idx[1:0]];
    assign tbl_data = t_data[tbl_idx[1:0]];

    logic [15:0] dmem [128];
    logic [15:0] rmem [128];

    typedef struct packed {
        logic [6:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t        exp_wr [$];
    logic [3:0] exp_end [$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int  lat = 3;
    bit  drop_read = 1'b0;
    bit  corrupt = 1'b0;
    bit  spur = 1'b0;
    bit  pend = 1'b0;
    int  wait_n = 0;
    logic [15:0] pend_rd = '0;
    logic [6:0]  last_wr_addr = '0;
    bit  last_was_wr = 1'b0;
    int  den_cnt = 0;
    int  first_den_cyc = 0;
    logic [6:0] first_rd_addr = '0;
    bit  first_rd_seen = 1'b0;

    bit  lock_en = 1'b1;
    int  lock_delay = 10;
    int  lock_cnt = 0;

    int  wr_cnt = 0;
    int  end_cnt = 0;
    int  done_cnt = 0;
    int  end_cyc = 0;
    wr_t        mon_e;
    logic [3:0] mon_end;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(posedge clk100) cyc <= cyc + 1;

    // DRP slave model: registers answer after lat cycles with DRDY.
    initial begin
        drp_drdy = 1'b0;
        drp_do   = '0;
        forever begin
            @(negedge clk100);
            drp_drdy = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (wait_n <= 1) begin
                        drp_drdy = 1'b1;
                        drp_do   = pend_rd;
                        pend     = 1'b0;
                    end else begin
                        wait_n--;
                    end
                end else if (spur && !drp_den) begin
                    drp_drdy = 1'b1;
                    drp_do   = 16'hDEAD;
                    spur     = 1'b0;
                end
                if (drp_den) begin
                    den_cnt++;
                    if (den_cnt == 1) first_den_cyc = cyc;
                    check("den_no_overlap", {31'd0, pend}, 32'd0);
                    if (drp_dwe) begin
                        dmem[drp_daddr] = drp_di;
                        last_wr_addr    = drp_daddr;
                        last_was_wr     = 1'b1;
                        pend_rd         = 16'h0;
                    end else begin
                        if (!first_rd_seen) begin
                            first_rd_seen = 1'b1;
                            first_rd_addr = drp_daddr;
                        end
                        pend_rd = dmem[drp_daddr];
                        if (corrupt && last_was_wr && last_wr_addr == drp_daddr)
                            pend_rd[0] = ~pend_rd[0];
                        last_was_wr = 1'b0;
                    end
                    if (drop_read && !drp_dwe) begin
                        drop_read = 1'b0;
                    end else begin
                        pend   = 1'b1;
                        wait_n = lat;
                    end
                end
            end
        end
    end

    // PLL lock model: LOCKED drops under RST, rises lock_delay cycles after release.
    initial begin
        pll_locked = 1'b0;
        forever begin
            @(negedge clk100);
            if (rst || pll_rst) begin
                pll_locked = 1'b0;
                lock_cnt   = 0;
            end else if (lock_en) begin
                if (lock_cnt >= lock_delay) pll_locked = 1'b1;
                else lock_cnt++;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT writes or ends a sequence.
    initial begin
        forever begin
            @(negedge clk100);
            if (!rst) begin
                if (drp_den && drp_dwe) begin
                    wr_cnt++;
                    check("wr_expected_pending", {31'd0, exp_wr.size() > 0}, 32'd1);
                    check("wr_pll_rst_high", {31'd0, pll_rst}, 32'd1);
                    if (exp_wr.size() > 0) begin
                        mon_e = exp_wr.pop_front();
                        check("wr_addr", {25'd0, drp_daddr}, {25'd0, mon_e.a});
                        check("wr_data", {16'd0, drp_di}, {16'd0, mon_e.d});
                    end
                end
                if (done || err) begin
                    end_cnt++;
                    end_cyc = cyc;
                    if (done) done_cnt++;
                    check("end_expected_pending", {31'd0, exp_end.size() > 0}, 32'd1);
                    if (exp_end.size() > 0) begin
                        mon_end = exp_end.pop_front();
                        check("end_kind", {28'd0, done, err, err_code}, {28'd0, mon_end});
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic new_table(input bit directed);
        int base;
        base = $urandom_range(0, 127);
        for (int i = 0; i < NE; i++) begin
            t_addr[i] = 7'((base + i * 29) % 128);
            t_mask[i] = 16'($urandom);
            t_data[i] = 16'($urandom);
        end
        if (directed) begin
            t_mask[0] = 16'hFF00;
            t_data[0] = 16'h0055;
        end
    endtask

    task automatic fill_mem(input bit constant);
        for (int a = 0; a < 128; a++) begin
            dmem[a] = constant ? 16'hAAAA : 16'($urandom);
            rmem[a] = dmem[a];
        end
    endtask

    // Reference: each entry keeps masked bits of the current register value.
    task automatic expect_writes(input int n);
        logic [15:0] v;
        for (int i = 0; i < n; i++) begin
            v = (rmem[t_addr[i]] & t_mask[i]) | (t_data[i] & ~t_mask[i]);
            rmem[t_addr[i]] = v;
            exp_wr.push_back({t_addr[i], v});
        end
    endtask

    task automatic pulse_start;
        @(posedge clk100);
        #1 start = 1'b1;
        @(posedge clk100);
        #1 start = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string name);
        int s;
        bit got;
        s   = end_cnt;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk100);
            #1;
            if (end_cnt != s) got = 1'b1;
        end
        check(name, {31'd0, got}, 32'd1);
    endtask

    task automatic end_run;
        check("wr_queue_drained", exp_wr.size(), 0);
        check("end_queue_drained", exp_end.size(), 0);
        exp_wr.delete();
        exp_end.delete();
    endtask

    task automatic new_run;
        den_cnt       = 0;
        done_cnt      = 0;
        first_rd_seen = 1'b0;
        last_was_wr   = 1'b0;
    endtask

    initial begin
        int n0;
        bit got;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NE; i++) begin
            t_addr[i] = '0;
            t_mask[i] = '0;
            t_data[i] = '0;
        end
        fill_mem(1'b1);
        repeat (4) @(posedge clk100);
        #1;
        check("rst_outputs", {busy, done, err, err_code, tbl_idx, drp_den, drp_dwe, drp_daddr, drp_di, pll_rst},
              '0);
        rst = 1'b0;
        repeat (2) @(posedge clk100);
        #1;
        check("idle_outputs", {busy, done, err, err_code, tbl_idx, drp_den, drp_dwe, pll_rst}, '0);

        // 1: directed entry0 0xAAAA -> 0xAA55, with a stray DRDY during HOLD
        new_run();
        lat = 3; lock_delay = 10; lock_en = 1'b1;
        fill_mem(1'b1);
        new_table(1'b1);
        expect_writes(NE);
        exp_end.push_back(4'b1000);
        pulse_start();
        spur = 1'b1;
        check("hold_busy_pll_rst", {30'd0, busy, pll_rst}, 32'd3);
        wait_end(3000, "basic_end");
        @(negedge clk100);
        check("basic_after", {28'd0, busy, pll_rst, err_code}, 32'd0);
        end_run();

        // 2: first read never answered -> code 1, 65 cycles after DEN
        new_run();
        drop_read = 1'b1;
        new_table(1'b0);
        exp_end.push_back({2'b01, 2'd1});
        pulse_start();
        wait_end(1000, "drdy_to_end");
        check("drdy_to_latency", end_cyc - first_den_cyc, 65);
        repeat (5) @(negedge clk100);
        check("drdy_to_hold", {29'd0, pll_rst, err_code}, {29'd0, 1'b1, 2'd1});
        drop_read = 1'b0;
        end_run();

        // 3: lock never arrives -> code 3, then a retry that locks
        new_run();
        lock_en = 1'b0;
        fill_mem(1'b0);
        new_table(1'b0);
        expect_writes(NE);
        exp_end.push_back({2'b01, 2'd3});
        pulse_start();
        wait_end(LOCK_TO + 2000, "lock_to_end");
        repeat (3) @(negedge clk100);
        check("lock_to_hold", {28'd0, busy, pll_rst, err_code}, {28'd0, 1'b0, 1'b1, 2'd3});
        end_run();
        new_run();
        lock_en = 1'b1;
        new_table(1'b0);
        expect_writes(NE);
        exp_end.push_back(4'b1000);
        pulse_start();
        wait_end(3000, "retry_end");
        @(negedge clk100);
        check("retry_after", {29'd0, pll_rst, err_code}, 32'd0);
        end_run();

        // 4: start pulses during RD_WAIT and LOCK_WAIT are ignored
        new_run();
        lat = 3;
        fill_mem(1'b0);
        new_table(1'b0);
        expect_writes(NE);
        exp_end.push_back(4'b1000);
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk100);
            #1;
            if (den_cnt > 0) got = 1'b1;
        end
        check("ign_first_den", {31'd0, got}, 32'd1);
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk100);
            #1;
            if (!pll_rst) got = 1'b1;
        end
        check("ign_release", {31'd0, got}, 32'd1);
        pulse_start();
        wait_end(3000, "ign_end");
        repeat (40) @(negedge clk100);
        check("ign_den_count", den_cnt, NE * DEN_PER_ENTRY);
        check("ign_done_count", done_cnt, 1);
        check("ign_idle", {31'd0, busy}, 32'd0);
        end_run();

        // 5: rst during WR_WAIT, then a clean run from tbl_idx 0
        new_run();
        lat = 4;
        fill_mem(1'b0);
        new_table(1'b0);
        expect_writes(NE);
        exp_end.push_back(4'b1000);
        n0 = wr_cnt;
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk100);
            #1;
            if (wr_cnt >= n0 + 2) got = 1'b1;
        end
        check("rst_mid_reach_wr", {31'd0, got}, 32'd1);
        @(posedge clk100);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_outputs", {busy, done, err, err_code, tbl_idx, drp_den, drp_dwe, drp_daddr, drp_di, pll_rst},
              '0);
        exp_wr.delete();
        exp_end.delete();
        repeat (3) @(posedge clk100);
        #1 rst = 1'b0;
        new_run();
        fill_mem(1'b0);
        new_table(1'b0);
        expect_writes(NE);
        exp_end.push_back(4'b1000);
        check("rst_mid_idx", {27'd0, tbl_idx}, 32'd0);
        pulse_start();
        wait_end(3000, "rst_mid_clean_end");
        check("rst_mid_first_addr", {25'd0, first_rd_addr}, {25'd0, t_addr[0]});
        end_run();

        // 6: readback corruption of bit 0
        new_run();
        lat = 2;
        corrupt = 1'b1;
        fill_mem(1'b1);
        new_table(1'b0);
        expect_writes(RB ? 1 : NE);
        exp_end.push_back(RB ? {2'b01, 2'd3} : 4'b1000);
        pulse_start();
        wait_end(3000, "rb_end");
        @(negedge clk100);
        check("rb_pll_rst", {31'd0, pll_rst}, {31'd0, RB});
        corrupt = 1'b0;
        end_run();

        // 7: randomized runs
        for (int r = 0; r < 6; r++) begin
            new_run();
            lat        = $urandom_range(1, 8);
            lock_delay = $urandom_range(0, 40);
            fill_mem(1'b0);
            new_table(1'b0);
            expect_writes(NE);
            exp_end.push_back(4'b1000);
            pulse_start();
            wait_end(3000, "rand_end");
            repeat (2) @(negedge clk100);
            check("rand_den_count", den_cnt, NE * DEN_PER_ENTRY);
            end_run();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_drp_sequencer.md
Name: pll_drp_sequencer

Overview:
- Reconfigures a PLLE2_ADV through its DRP port at run time, e.g. to switch the CLKOUTn divide and phase settings driving the counter clocks.
- Sequence: hold the PLL in reset, do a read-modify-write of each DRP register from a parent-supplied table, release reset, then wait for LOCKED with a timeout.
- Sits between system control logic (clk100 domain) and the PLL's DCLK/DEN/DWE/DADDR/DI/DO/DRDY/RST/LOCKED pins; DCLK is clk100.

Parameters:
- NUM_ENTRIES, 8, number of table entries written per reconfiguration (1..32).
- DRP_TIMEOUT, 64, max clk100 cycles to wait for DRDY after a DEN pulse.
- LOCK_TIMEOUT, 65536, max clk100 cycles to wait for synchronized LOCKED after RST release.
- RST_HOLD, 16, clk100 cycles pll_rst is held before the first DRP access.

Ports:
- clk100  in  1  system clock, also drives PLL DCLK
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin reconfiguration
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse: sequence finished and PLL locked
- err  out  1  one-cycle pulse: sequence aborted
- err_code  out  2  1=DRDY timeout on read, 2=DRDY timeout on write, 3=lock timeout (readback mismatch when the optional feature is enabled); held until the next start
- tbl_idx  out  5  current table index
- tbl_addr  in  7  DRP address for tbl_idx (combinational from parent)
- tbl_mask  in  16  1 = preserve existing bit
- tbl_data  in  16  new bit values where mask = 0
- drp_den  out  1  PLL DEN
- drp_dwe  out  1  PLL DWE
- drp_daddr  out  7  PLL DADDR
- drp_di  out  16  PLL DI
- drp_do  in  16  PLL DO
- drp_drdy  in  1  PLL DRDY
- pll_rst  out  1  PLL RST (ORed with rst at top level by the parent)
- pll_locked  in  1  PLL LOCKED (asynchronous to clk100)

Behaviour:
- Reset values: busy=0, done=0, err=0, err_code=0, tbl_idx=0, drp_den=0, drp_dwe=0, drp_daddr=0, drp_di=0, pll_rst=0. FSM enters IDLE and the synchronizer flops clear.
- pll_locked passes through a 2-flop synchronizer. Every reference to "locked" below means the synchronized value.
- IDLE:
  - start=1 -> HOLD. Sets busy=1, pll_rst=1, tbl_idx=0, err_code=0, hold counter=0.
  - start while busy=1 is ignored; no queueing.
- HOLD: count RST_HOLD cycles, then -> RD.
- RD:
  - One cycle with drp_den=1, drp_dwe=0, drp_daddr=tbl_addr, then -> RD_WAIT.
  - tbl_addr/mask/data are sampled into registers in this cycle and used for the rest of the entry.
- RD_WAIT:
  - On drp_drdy: capture rd = drp_do, then -> WR.
  - If DRP_TIMEOUT cycles pass with no DRDY -> FAIL with code 1.
- WR:
  - One cycle with drp_den=1, drp_dwe=1, same address.
  - drp_di = (rd & mask) | (data & ~mask). Then -> WR_WAIT.
- WR_WAIT:
  - On DRDY: if tbl_idx = NUM_ENTRIES-1 -> RELEASE; otherwise tbl_idx+1 and -> RD.
  - Timeout -> FAIL with code 2.
- Strobes:
  - DEN is never asserted while a previous access is outstanding.
  - DRDY arriving in IDLE, HOLD or RELEASE is ignored.
- RELEASE: set pll_rst=0, clear the timeout counter, then -> LOCK_WAIT.
- LOCK_WAIT:
  - locked=1 -> DONE.
  - LOCK_TIMEOUT cycles without lock -> FAIL with code 3.
  - A locked value still high from before reconfiguration cannot satisfy this: the PLL drops LOCKED under RST and HOLD is at least 2 cycles longer than the synchronizer.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- FAIL: err=1 for one cycle, err_code latched, pll_rst=1 held (PLL left in reset), busy=0 -> IDLE. The next start retries.
- Counters are sized to their parameter with clog2 and saturate; no wrap-around.
- rst asserted mid-sequence: everything returns to reset values immediately, including pll_rst=0. The parent's OR keeps the PLL in reset while rst is high.

Optional Feature:
- Macro: PLL_DRP_READBACK_EN.
- Defined: after WR_WAIT, add states VRD/VRD_WAIT that re-read the same address. The value must equal the written drp_di; a mismatch -> FAIL with code 3. A readback DRDY timeout uses code 1.
- Not defined: no verification reads; code 3 means lock timeout only.

Test Plan:
- NUM_ENTRIES=2, DRP model returns 0xAAAA with DRDY 3 cycles after DEN, entry0 mask=0xFF00 data=0x0055, start -> DI=0xAA55 to entry0 address; pll_rst high from start to after the second write; locked raised 10 cycles later -> one done pulse, busy low, err_code=0.
- Model never asserts DRDY on the first read -> err pulse 65 cycles after DEN (DRP_TIMEOUT=64), err_code=1, pll_rst stays 1.
- Writes complete but pll_locked stays 0 -> err_code=3 after 65536 cycles; a second start then succeeds with locked asserted -> done, pll_rst=0.
- start pulses during RD_WAIT and LOCK_WAIT -> ignored; exactly NUM_ENTRIES×2 DEN pulses and one done.
- rst asserted in WR_WAIT -> all outputs 0 in the same cycle; after release, start runs a full clean sequence from tbl_idx=0.
- PLL_DRP_READBACK_EN defined, model corrupts bit 0 on readback -> err_code=3 before RELEASE; with the macro undefined the same model -> done.
